hit_score_keeper: RTL and testbench



---
 rtl/hit_score_keeper_if.sv | 26 ++
 rtl/hit_score_keeper.sv | 108 ++++++++++
 tb/tb_hit_score_keeper.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/hit_score_keeper_if.sv
// hit_score_keeper_if: game-event inputs and score/state outputs of the score keeper
//   master: producer side (collision/game controller, testbench)
//   slave : score keeper side
//   startOfFrame, score_hit, penalty_hit, start_game : one-cycle event pulses
//   score_bcd, high_score_bcd                        : 3-digit packed BCD
//   lives, playing, invuln, game_over                : game state for the drawers
interface hit_score_keeper_if;
   logic        startOfFrame;
   logic        score_hit;
   logic        penalty_hit;
   logic        start_game;
   logic [11:0] score_bcd;
   logic [2:0]  lives;
   logic        playing;
   logic        invuln;
   logic        game_over;
   logic [11:0] high_score_bcd;
   modport master (
      output startOfFrame, score_hit, penalty_hit, start_game,
      input  score_bcd, lives, playing, invuln, game_over, high_score_bcd
   );
   modport slave (
      input  startOfFrame, score_hit, penalty_hit, start_game,
      output score_bcd, lives, playing, invuln, game_over, high_score_bcd
   );
endinterface

// File: rtl/hit_score_keeper.sv
// hit_score_keeper: BCD score, lives and IDLE/PLAY/INVULN/GAME_OVER game state machine
//   clk    : system clock
//   resetN : asynchronous active-low reset
//   bus    : hit_score_keeper_if.slave (event pulses in, registered score/state out)
//   Optional macro HIGH_SCORE_TRACK_EN keeps the best final score in high_score_bcd;
//   without it high_score_bcd is constant 12'h000.
module hit_score_keeper #(
   parameter int POINTS_PER_HIT = 1,
   parameter int INIT_LIVES     = 3,
   parameter int INVULN_FRAMES  = 30
) (
   input logic              clk,
   input logic              resetN,
   hit_score_keeper_if.slave bus
);
   typedef enum logic [1:0] {IDLE, PLAY, INVULN, GAME_OVER} state_t;
   state_t      state, state_nx;
   logic [11:0] score, score_nx, high;
   logic [2:0]  lives, lives_nx, lives_dec;
   logic [7:0]  frame_cnt, frame_nx, frame_inc;
   logic        playing, invuln, game_over;
   logic        playing_nx, invuln_nx, game_over_nx;
   logic        load, scoring, lose;

   // Saturating packed-BCD add of POINTS_PER_HIT; carries ripple ones->tens->hundreds.
   function automatic logic [11:0] bcd_add(input logic [11:0] s);
      logic [4:0] o, t, h;
      o = 5'(s[3:0]) + 5'(POINTS_PER_HIT);
      t = 5'(s[7:4]) + ((o > 5'd9) ? 5'd1 : 5'd0);
      h = 5'(s[11:8]) + ((t > 5'd9) ? 5'd1 : 5'd0);
      o = (o > 5'd9) ? o - 5'd10 : o;
      t = (t > 5'd9) ? t - 5'd10 : t;
      return (h > 5'd9) ? 12'h999 : {h[3:0], t[3:0], o[3:0]};
   endfunction

   // A fresh load beats any same-cycle hit in IDLE/GAME_OVER; penalties only count in PLAY.
   assign load      = (state == IDLE || state == GAME_OVER) && bus.start_game;
   assign scoring   = (state == PLAY || state == INVULN) && bus.score_hit;
   assign lose      = (state == PLAY) && bus.penalty_hit;
   assign lives_dec = (lives != 3'd0) ? lives - 3'd1 : 3'd0;
   assign frame_inc = frame_cnt + 8'd1;

   always_ff @(posedge clk or negedge resetN)
      if (!resetN) state <= IDLE;
      else state <= state_nx;

   always_comb begin
      state_nx = state;
      case (state)
         IDLE, GAME_OVER: if (bus.start_game) state_nx = PLAY;
         PLAY:            if (lose) state_nx = (lives_dec == 3'd0) ? GAME_OVER : INVULN;
         INVULN:          if (bus.startOfFrame && frame_inc == 8'(INVULN_FRAMES)) state_nx = PLAY;
         default:         state_nx = IDLE;
      endcase
   end

   // Flags are decoded from the next state so they line up with the registered score/lives.
   always_comb begin
      playing_nx   = state_nx == PLAY || state_nx == INVULN;
      invuln_nx    = state_nx == INVULN;
      game_over_nx = state_nx == GAME_OVER;
   end

   always_comb begin
      score_nx = load ? 12'h000 : scoring ? bcd_add(score) : score;
      lives_nx = load ? 3'(INIT_LIVES) : lose ? lives_dec : lives;
      frame_nx = (load || lose) ? 8'd0 : (state == INVULN && bus.startOfFrame) ? frame_inc : frame_cnt;
   end

   always_ff @(posedge clk or negedge resetN)
      if (!resetN) begin
         score     <= 12'h000;
         lives     <= 3'd0;
         frame_cnt <= 8'd0;
         playing   <= 1'b0;
         invuln    <= 1'b0;
         game_over <= 1'b0;
      end else begin
         score     <= score_nx;
         lives     <= lives_nx;
         frame_cnt <= frame_nx;
         playing   <= playing_nx;
         invuln    <= invuln_nx;
         game_over <= game_over_nx;
      end

`ifdef HIGH_SCORE_TRACK_EN
   // go_entry marks the first GAME_OVER cycle, when score holds the final value of the game.
   logic go_entry;
   always_ff @(posedge clk or negedge resetN)
      if (!resetN) begin
         go_entry <= 1'b0;
         high     <= 12'h000;
      end else begin
         go_entry <= game_over_nx && !game_over;
         if (go_entry && score > high) high <= score;
      end
`else
   assign high = 12'h000;
`endif

   assign bus.score_bcd      = score;
   assign bus.lives          = lives;
   assign bus.playing        = playing;
   assign bus.invuln         = invuln;
   assign bus.game_over      = game_over;
   assign bus.high_score_bcd = high;
endmodule

// File: tb/tb_hit_score_keeper.sv
// tb_hit_score_keeper: vector table, directed corner sequences and random play against a decimal reference model
module tb_hit_score_keeper;
   localparam int P = 7;
   localparam int L = 3;
   localparam int F = 4;

   logic clk = 0;
   logic resetN = 0;
   int   passed = 0;
   int   total  = 0;

   hit_score_keeper_if bus();

   hit_score_keeper #(.POINTS_PER_HIT(P), .INIT_LIVES(L), .INVULN_FRAMES(F)) dut (
      .clk(clk),
      .resetN(resetN),
      .bus(bus.slave)
   );

   always #5 clk = ~clk;

   // Reference model: score as a plain decimal integer, mode 0 idle / 1 play / 2 invuln / 3 game over.
   int m_mode, m_score, m_lives, m_cnt, m_high;
   bit m_pend;

   function automatic logic [11:0] to_bcd(input int v);
      return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   task automatic model_reset();
      m_mode = 0; m_score = 0; m_lives = 0; m_cnt = 0; m_high = 0; m_pend = 0;
   endtask

   task automatic model_step(input bit sof, sh, ph, sg);
`ifdef HIGH_SCORE_TRACK_EN
      if (m_pend && m_score > m_high) m_high = m_score;
`endif
      m_pend = 0;
      case (m_mode)
         0, 3: if (sg) begin m_score = 0; m_lives = L; m_cnt = 0; m_mode = 1; end
         1: begin
            if (sh) m_score = (m_score + P > 999) ? 999 : m_score + P;
            if (ph) begin
               m_lives--;
               if (m_lives == 0) begin m_mode = 3; m_pend = 1; end
               else begin m_mode = 2; m_cnt = 0; end
            end
         end
         default: begin
            if (sh) m_score = (m_score + P > 999) ? 999 : m_score + P;
            if (sof) begin m_cnt++; if (m_cnt == F) m_mode = 1; end
         end
      endcase
   endtask

   function automatic logic [29:0] dut_out();
      return {bus.score_bcd, bus.lives, bus.playing, bus.invuln, bus.game_over, bus.high_score_bcd};
   endfunction

   function automatic logic [29:0] model_out();
      return {to_bcd(m_score), 3'(m_lives), m_mode == 1 || m_mode == 2, m_mode == 2, m_mode == 3, to_bcd(m_high)};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic cycle(input bit sof, sh, ph, sg, input string name = "model");
      bus.startOfFrame = sof; bus.score_hit = sh; bus.penalty_hit = ph; bus.start_game = sg;
      @(posedge clk);
      model_step(sof, sh, ph, sg);
      #1;
      chk(name, 32'(dut_out()), 32'(model_out()));
      bus.startOfFrame = 0; bus.score_hit = 0; bus.penalty_hit = 0; bus.start_game = 0;
   endtask

   task automatic do_reset();
      resetN = 0;
      repeat (2) @(posedge clk);
      #1 chk("reset_state", 32'(dut_out()), 32'h0);
      @(negedge clk);
      resetN = 1;
      model_reset();
   endtask

   task automatic play_game(input int hits);
      cycle(0, 0, 0, 1, "hs_start");
      repeat (hits) cycle(1, 1, 0, 0, "hs_hit");
      repeat (L) begin
         cycle(0, 0, 1, 0, "hs_pen");
         repeat (F) cycle(1, 0, 0, 0, "hs_frame");
      end
      repeat (2) cycle(0, 0, 0, 0, "hs_idle");
   endtask

   typedef struct {
      logic sof, sh, ph, sg;
      logic [11:0] score;
      logic [2:0] lives;
      logic p, i, g;
   } vec_t;
   vec_t tbl[20];

`ifdef HIGH_SCORE_TRACK_EN
   localparam logic [11:0] HS1 = 12'h021, HS2 = 12'h021, HS3 = 12'h035;
`else
   localparam logic [11:0] HS1 = 12'h000, HS2 = 12'h000, HS3 = 12'h000;
`endif

   initial begin
      bus.startOfFrame = 0; bus.score_hit = 0; bus.penalty_hit = 0; bus.start_game = 0;
      model_reset();
      // sof sh ph sg | score lives playing invuln game_over
      tbl[0]  = '{0, 1, 0, 0, 12'h000, 3'd0, 0, 0, 0};
      tbl[1]  = '{0, 0, 0, 1, 12'h000, 3'd3, 1, 0, 0};
      tbl[2]  = '{0, 1, 0, 0, 12'h007, 3'd3, 1, 0, 0};
      tbl[3]  = '{1, 1, 0, 0, 12'h014, 3'd3, 1, 0, 0};
      tbl[4]  = '{0, 0, 0, 1, 12'h014, 3'd3, 1, 0, 0};
      tbl[5]  = '{0, 0, 1, 0, 12'h014, 3'd2, 1, 1, 0};
      tbl[6]  = '{1, 0, 0, 0, 12'h014, 3'd2, 1, 1, 0};
      tbl[7]  = '{1, 0, 1, 0, 12'h014, 3'd2, 1, 1, 0};
      tbl[8]  = '{0, 1, 0, 0, 12'h021, 3'd2, 1, 1, 0};
      tbl[9]  = '{1, 0, 0, 0, 12'h021, 3'd2, 1, 1, 0};
      tbl[10] = '{1, 0, 1, 0, 12'h021, 3'd2, 1, 0, 0};
      tbl[11] = '{0, 0, 1, 0, 12'h021, 3'd1, 1, 1, 0};
      tbl[12] = '{1, 0, 0, 0, 12'h021, 3'd1, 1, 1, 0};
      tbl[13] = '{1, 0, 0, 0, 12'h021, 3'd1, 1, 1, 0};
      tbl[14] = '{1, 0, 0, 0, 12'h021, 3'd1, 1, 1, 0};
      tbl[15] = '{1, 0, 0, 0, 12'h021, 3'd1, 1, 0, 0};
      tbl[16] = '{0, 1, 1, 0, 12'h028, 3'd0, 0, 0, 1};
      tbl[17] = '{1, 1, 0, 0, 12'h028, 3'd0, 0, 0, 1};
      tbl[18] = '{0, 0, 1, 0, 12'h028, 3'd0, 0, 0, 1};
      tbl[19] = '{0, 1, 0, 1, 12'h000, 3'd3, 1, 0, 0};

      do_reset();
      for (int k = 0; k < 20; k++) begin
         cycle(tbl[k].sof, tbl[k].sh, tbl[k].ph, tbl[k].sg, $sformatf("model_vec%0d", k));
         chk($sformatf("vec%0d", k), 32'({bus.score_bcd, bus.lives, bus.playing, bus.invuln, bus.game_over}),
             32'({tbl[k].score, tbl[k].lives, tbl[k].p, tbl[k].i, tbl[k].g}));
      end

      // Saturation: 142 hits of 7 reach 994, the next one would pass 999.
      do_reset();
      cycle(0, 0, 0, 1, "sat_start");
      repeat (142) cycle(1, 1, 0, 0, "sat_hit");
      chk("sat_994", 32'(bus.score_bcd), 32'h994);
      cycle(1, 1, 0, 0, "sat_hit");
      chk("sat_999", 32'(bus.score_bcd), 32'h999);
      repeat (3) cycle(1, 1, 0, 0, "sat_hold");
      chk("sat_hold", 32'(bus.score_bcd), 32'h999);

      // Asynchronous reset in the middle of INVULN clears outputs before any clock edge.
      cycle(0, 0, 1, 0, "ar_pen");
      chk("ar_invuln", 32'(bus.invuln), 32'h1);
      @(negedge clk);
      resetN = 0;
      #1 chk("async_reset", 32'(dut_out()), 32'h0);
      model_reset();
      @(negedge clk);
      resetN = 1;
      cycle(0, 1, 1, 0, "ar_idle");
      chk("ar_needs_start", 32'(dut_out()), 32'h0);
      cycle(0, 0, 0, 1, "ar_start");

      // High score across three games ending at 021, 014 and 035.
      do_reset();
      play_game(3);
      chk("high_g1", 32'(bus.high_score_bcd), 32'(HS1));
      play_game(2);
      chk("high_g2", 32'(bus.high_score_bcd), 32'(HS2));
      play_game(5);
      chk("high_g3", 32'(bus.high_score_bcd), 32'(HS3));

      // Random play.
      do_reset();
      for (int k = 0; k < 4000; k++)
         cycle($urandom_range(3) == 0, $urandom_range(3) == 0, $urandom_range(5) == 0,
               $urandom_range(15) == 0, "random");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
